// File: rtl/imm_pkg.sv
// Shared definitions for the registered immediate generator.
// Provides ImmSrc codes, the buffered entry type and a legality helper.
package imm_pkg;

  localparam logic [2:0] IMM_I  = 3'b000;
  localparam logic [2:0] IMM_S  = 3'b001;
  localparam logic [2:0] IMM_B  = 3'b010;
  localparam logic [2:0] IMM_J  = 3'b011;
  localparam logic [2:0] IMM_U  = 3'b100;
  localparam logic [2:0] IMM_SH = 3'b101;

  localparam int XLEN_MAX = 64;

  typedef struct packed {
    logic [XLEN_MAX-1:0] imm;
    logic                err;
  } imm_ent_t;

  function automatic logic imm_src_legal(
    input logic [2:0] src
  );
    return src <= IMM_SH;
  endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational RV32I/RV64I immediate format decode (imm_decode).
// Ports: instr[31:7], src (ImmSrc) in; imm (XLEN), err out.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [24:0]     instr,
  input  logic [2:0]      src,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  // Re-base so field slices read like the ISA manual.
  logic [31:7] ir;
  assign ir = instr;

  always_comb begin
    imm = '0;
    err = 1'b0;
    unique case (1'b1)
      (src == IMM_I):
        imm = {{(XLEN-12){ir[31]}}, ir[31:20]};
      (src == IMM_S):
        imm = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
      (src == IMM_B):
        imm = {{(XLEN-13){ir[31]}}, ir[31], ir[7],
               ir[30:25], ir[11:8], 1'b0};
      (src == IMM_J):
        imm = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12],
               ir[20], ir[30:21], 1'b0};
      // Size cast of a signed value sign-extends for RV64.
      (src == IMM_U):
        imm = XLEN'($signed({ir[31:12], 12'b0}));
      (src == IMM_SH):
        imm = {{(XLEN-SHAMT_W){1'b0}}, ir[20 +: SHAMT_W]};
      default:
        err = !imm_src_legal(src);
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry valid/ready skid buffer.
// Ports: clk, reset, flush, in_valid/in_ready, instr, ImmSrc,
//   out_valid/out_ready, ImmExt, imm_err; err_count if IMMGEN_STAT_EN.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [24:0]     instr,
  input  logic [2:0]      ImmSrc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ImmExt,
  output logic            imm_err
`ifdef IMMGEN_STAT_EN
  ,
  output logic [15:0]     err_count
`endif
);

  logic [XLEN-1:0] dec_imm;
  logic            dec_err;
  imm_ent_t        new_e;
  imm_ent_t        or_q;
  imm_ent_t        sr_q;
  logic            or_v;
  logic            sr_v;
  logic            accept;
  logic            drain;
  logic            unused_hi;

  imm_decode #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_dec (
    .instr (instr),
    .src   (ImmSrc),
    .imm   (dec_imm),
    .err   (dec_err)
  );

  assign new_e = '{imm: XLEN_MAX'(dec_imm), err: dec_err};

  // in_ready depends only on state, never on out_ready.
  assign in_ready  = !sr_v;
  assign accept    = in_valid && in_ready;
  assign drain     = or_v && out_ready;
  assign out_valid = or_v;
  assign ImmExt    = or_q.imm[XLEN-1:0];
  assign imm_err   = or_q.err;

  // Entry bits above XLEN are always zero.
  assign unused_hi = ^or_q.imm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      or_v <= 1'b0;
      sr_v <= 1'b0;
      or_q <= '0;
      sr_q <= '0;
    end else if (flush) begin
      or_v <= 1'b0;
      sr_v <= 1'b0;
    end else if (drain) begin
      if (sr_v) begin
        // in_ready was low, so nothing is accepted here.
        or_q <= sr_q;
        sr_v <= 1'b0;
      end else if (accept) begin
        or_q <= new_e;
      end else begin
        or_v <= 1'b0;
      end
    end else if (!or_v) begin
      if (accept) begin
        or_q <= new_e;
        or_v <= 1'b1;
      end
    end else if (accept) begin
      sr_q <= new_e;
      sr_v <= 1'b1;
    end
  end

`ifdef IMMGEN_STAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (accept && !flush && dec_err
                 && err_count != 16'hFFFF) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe at XLEN=32 and XLEN=64.
// Both instances share stimulus; each has its own expected queue.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [24:0] instr = '0;
  logic [2:0]  imm_src = '0;

  logic        rdy32, rdy64, ov32, ov64, er32, er64;
  logic [31:0] imm32;
  logic [63:0] imm64;
`ifdef IMMGEN_STAT_EN
  logic [15:0] cnt32, cnt64;
`endif

  int checks = 0;
  int errors = 0;

  logic [64:0] q32[$];
  logic [64:0] q64[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SHAMT_W(5)) u32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32),
    .instr(instr), .ImmSrc(imm_src),
    .out_valid(ov32), .out_ready(out_ready),
    .ImmExt(imm32), .imm_err(er32)
`ifdef IMMGEN_STAT_EN
    , .err_count(cnt32)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .SHAMT_W(6)) u64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64),
    .instr(instr), .ImmSrc(imm_src),
    .out_valid(ov64), .out_ready(out_ready),
    .ImmExt(imm64), .imm_err(er64)
`ifdef IMMGEN_STAT_EN
    , .err_count(cnt64)
`endif
  );

  task automatic chk(input string nm,
                     input logic [64:0] act,
                     input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", nm, act, exp);
    end
  endtask

  // Monitor: pops on every transfer (out_valid && out_ready).
  always @(negedge clk) begin
    if (!reset && ov32 && out_ready) begin
      if (q32.size() == 0) begin
        chk("x32 unexpected", {er32, 32'h0, imm32}, 65'h0);
      end else begin
        chk("x32 imm", {er32, 32'h0, imm32}, q32.pop_front());
      end
    end
    if (!reset && ov64 && out_ready) begin
      if (q64.size() == 0) begin
        chk("x64 unexpected", {er64, imm64}, 65'h0);
      end else begin
        chk("x64 imm", {er64, imm64}, q64.pop_front());
      end
    end
  end

  // Starts and returns at posedge+1.
  task automatic push(input logic [31:0] raw,
                      input logic [2:0]  src,
                      input logic [63:0] e32,
                      input logic [63:0] e64,
                      input logic        err);
    int n = 0;
    instr    = raw[31:7];
    imm_src  = src;
    in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (rdy32) begin
        q32.push_back({err, e32});
        q64.push_back({err, e64});
        break;
      end
      n++;
      if (n > 100) begin
        chk("push timeout", 65'(n), 65'h0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 65'(q32.size() + q64.size()), 65'h0);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst ov", {63'h0, ov32, ov64}, 65'h0);
    chk("rst rdy", {63'h0, rdy32, rdy64}, 65'h3);
    chk("rst imm", {1'b0, imm64}, 65'h0);
    chk("rst err", {63'h0, er32, er64}, 65'h0);
`ifdef IMMGEN_STAT_EN
    chk("rst cnt", {33'h0, cnt32, cnt64}, 65'h0);
`endif
    cyc(2);
    reset = 1'b0;
    out_ready = 1'b1;
    cyc(1);

    push(32'hFFF00093, 3'b000, 64'hFFFFFFFF,
         64'hFFFFFFFFFFFFFFFF, 1'b0);
    push(32'hFE512E23, 3'b001, 64'hFFFFFFFC,
         64'hFFFFFFFFFFFFFFFC, 1'b0);
    push(32'hFFDFF06F, 3'b011, 64'hFFFFFFFC,
         64'hFFFFFFFFFFFFFFFC, 1'b0);
    push(32'h123450B7, 3'b100, 64'h12345000,
         64'h0000000012345000, 1'b0);
    push(32'hFE000EE3, 3'b010, 64'hFFFFFFFC,
         64'hFFFFFFFFFFFFFFFC, 1'b0);
    push(32'h00000463, 3'b010, 64'h8, 64'h8, 1'b0);
    push(32'h03F01013, 3'b101, 64'h1F, 64'h3F, 1'b0);
    push(32'h00501013, 3'b101, 64'h5, 64'h5, 1'b0);
    push(32'h800000B7, 3'b100, 64'h80000000,
         64'hFFFFFFFF80000000, 1'b0);
    push(32'h7FF00093, 3'b000, 64'h7FF, 64'h7FF, 1'b0);
    wait_empty();

    // Stall: two entries fill OR and SR, third waits.
    out_ready = 1'b0;
    push(32'hFFF00093, 3'b000, 64'hFFFFFFFF,
         64'hFFFFFFFFFFFFFFFF, 1'b0);
    push(32'hFE512E23, 3'b001, 64'hFFFFFFFC,
         64'hFFFFFFFFFFFFFFFC, 1'b0);
    chk("full rdy", {63'h0, rdy32, rdy64}, 65'h0);
    chk("full ov", {63'h0, ov32, ov64}, 65'h3);
    fork
      push(32'h123450B7, 3'b100, 64'h12345000,
           64'h0000000012345000, 1'b0);
      begin
        cyc(2);
        chk("blocked rdy", {63'h0, rdy32, rdy64}, 65'h0);
        chk("hold imm", {33'h0, imm32}, 65'hFFFFFFFF);
        out_ready = 1'b1;
      end
    join
    wait_empty();
    chk("resume rdy", {63'h0, rdy32, rdy64}, 65'h3);

    // Flush with a same-cycle (illegal) input that must be dropped.
    out_ready = 1'b0;
    push(32'hFFF00093, 3'b000, 64'hFFFFFFFF,
         64'hFFFFFFFFFFFFFFFF, 1'b0);
    push(32'hFE512E23, 3'b001, 64'hFFFFFFFC,
         64'hFFFFFFFFFFFFFFFC, 1'b0);
    instr    = 25'h1FFFFFF;
    imm_src  = 3'b111;
    in_valid = 1'b1;
    flush    = 1'b1;
    cyc(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    q32.delete();
    q64.delete();
    chk("flush ov", {63'h0, ov32, ov64}, 65'h0);
    chk("flush rdy", {63'h0, rdy32, rdy64}, 65'h3);
    out_ready = 1'b1;
    cyc(3);
    chk("flush ov2", {63'h0, ov32, ov64}, 65'h0);

    // Illegal codes.
    repeat (3) push(32'hFFFFFFFF, 3'b111, 64'h0, 64'h0, 1'b1);
    wait_empty();
`ifdef IMMGEN_STAT_EN
    chk("cnt3", {33'h0, cnt32, cnt64}, {33'h0, 16'd3, 16'd3});
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    chk("cnt flush", {33'h0, cnt32, cnt64}, {33'h0, 16'd3, 16'd3});
`endif
    push(32'h12345678, 3'b110, 64'h0, 64'h0, 1'b1);
    wait_empty();
`ifdef IMMGEN_STAT_EN
    chk("cnt4", {33'h0, cnt32, cnt64}, {33'h0, 16'd4, 16'd4});
`endif

    // Reset mid-stall clears everything asynchronously.
    out_ready = 1'b0;
    push(32'hFFF00093, 3'b000, 64'hFFFFFFFF,
         64'hFFFFFFFFFFFFFFFF, 1'b0);
    push(32'hFE512E23, 3'b001, 64'hFFFFFFFC,
         64'hFFFFFFFFFFFFFFFC, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst ov", {63'h0, ov32, ov64}, 65'h0);
    chk("arst rdy", {63'h0, rdy32, rdy64}, 65'h3);
    chk("arst imm", {1'b0, imm64}, 65'h0);
    q32.delete();
    q64.delete();
    cyc(2);
    reset = 1'b0;
    out_ready = 1'b1;
    cyc(3);
    chk("post rst ov", {63'h0, ov32, ov64}, 65'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
